// File: rtl/rv_regs_pkg.sv
// Shared register-file definitions for the write-back path.
// Holds register addressing constants, the write request type and the controller FSM states.
package rv_regs_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;
  localparam int WB_XLEN    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_req_t;

  typedef enum logic {WB_CLEAR, WB_RUN} wb_state_e;
endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// Circular load-result FIFO.
// Per-entry rd/valid vectors are exported for the hazard and WAW comparators.
module wb_fifo
  import rv_regs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic [REG_ADDR_W-1:0]               push_rd,
  input  logic [XLEN-1:0]                     push_data,
  input  logic                                pop,
  output logic [REG_ADDR_W-1:0]               head_rd,
  output logic [XLEN-1:0]                     head_data,
  output logic                                full,
  output logic                                empty,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd,
  output logic [DEPTH-1:0]                    ent_vld
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_mem_q, rd_mem_d;
  logic [DEPTH-1:0][XLEN-1:0]       data_mem_q, data_mem_d;
  logic [DEPTH-1:0]                 vld_q, vld_d;
  logic [PW-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                    count_q, count_d;
  logic                             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO refuses the push even if the head pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign ent_rd    = rd_mem_q;
  assign ent_vld   = vld_q;

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    vld_d      = vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (do_push) begin
      rd_mem_d[wr_ptr_q]   = push_rd;
      data_mem_d[wr_ptr_q] = push_data;
      vld_d[wr_ptr_q]      = 1'b1;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_mem_q   <= '0;
      data_mem_q <= '0;
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
      vld_q      <= vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-port owner: zeroes x1..x31 after reset, then merges ALU
// results and buffered load results onto WE3/A3/WD3 and flags RAW hazards.
module reg_wb_ctrl
  import rv_regs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_pending,
  output logic                  rs2_pending,
  output logic                  WE3,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3,
  output logic                  init_done
);
  wb_state_e             state_q, state_d;
  logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
  logic                  we3_q, we3_d;
  logic [REG_ADDR_W-1:0] a3_q, a3_d;
  logic [XLEN-1:0]       wd3_q, wd3_d;
  logic                  init_done_q, init_done_d;

  logic                             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REG_ADDR_W-1:0]            head_rd;
  logic [XLEN-1:0]                  head_data;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
  logic [DEPTH-1:0]                 ent_vld;

  logic run, ld_hs, alu_hs, alu_wr, ld_wr, bypass, alu_stall;
  logic alu_in_fifo, rs1_in_fifo, rs2_in_fifo;

  wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_rd   (ld_rd),
    .push_data (ld_data),
    .pop       (fifo_pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_rd    (ent_rd),
    .ent_vld   (ent_vld)
  );

  always_comb begin
    alu_in_fifo = 1'b0;
    rs1_in_fifo = 1'b0;
    rs2_in_fifo = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent_rd[i] == alu_rd) alu_in_fifo = 1'b1;
      if (ent_vld[i] && ent_rd[i] == rs1)    rs1_in_fifo = 1'b1;
      if (ent_vld[i] && ent_rd[i] == rs2)    rs2_in_fifo = 1'b1;
    end
  end

  assign run      = (state_q == WB_RUN);
  assign ld_ready = run && !fifo_full;
  assign ld_hs    = ld_valid && ld_ready;
  // A queued or same-cycle load to the same rd is older, so the ALU result waits behind it.
  assign alu_stall = (alu_rd != X0) && (alu_in_fifo || (ld_hs && ld_rd == alu_rd));
  assign alu_ready = run && !alu_stall;
  assign alu_hs    = alu_valid && alu_ready;
  assign alu_wr    = alu_hs && (alu_rd != X0);
  assign ld_wr     = ld_hs && (ld_rd != X0);

  // An idle port lets a fresh load skip the FIFO and write with ALU latency.
  assign fifo_pop  = run && !alu_wr && !fifo_empty;
  assign bypass    = run && !alu_wr && fifo_empty && ld_wr;
  assign fifo_push = ld_wr && !bypass;

  assign rs1_pending = run && (rs1 != X0) && (rs1_in_fifo || (we3_q && a3_q == rs1));
  assign rs2_pending = run && (rs2 != X0) && (rs2_in_fifo || (we3_q && a3_q == rs2));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we3_d       = 1'b0;
    a3_d        = a3_q;
    wd3_d       = wd3_q;
    init_done_d = init_done_q;
    case (state_q)
      WB_CLEAR: begin
        we3_d = 1'b1;
        a3_d  = cnt_q;
        wd3_d = '0;
        cnt_d = cnt_q + REG_ADDR_W'(1);
        if (cnt_q == REG_ADDR_W'(NUM_REGS - 1)) begin
          state_d     = WB_RUN;
          init_done_d = 1'b1;
        end
      end
      WB_RUN: begin
        if (alu_wr) begin
          we3_d = 1'b1;
          a3_d  = alu_rd;
          wd3_d = alu_data;
        end else if (fifo_pop) begin
          we3_d = 1'b1;
          a3_d  = head_rd;
          wd3_d = head_data;
        end else if (bypass) begin
          we3_d = 1'b1;
          a3_d  = ld_rd;
          wd3_d = ld_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WB_CLEAR;
      cnt_q       <= REG_ADDR_W'(1);
      we3_q       <= 1'b0;
      a3_q        <= '0;
      wd3_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we3_q       <= we3_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      init_done_q <= init_done_d;
    end
  end

  assign WE3       = we3_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;
  assign init_done = init_done_q;
endmodule
